// File: rtl/sr_latch_driver.sv
// Command-side driver for the cross-coupled SR latch cell.
// Takes a target-level request over valid/ready. Issues a fixed-width,
// mutually exclusive set or reset pulse. Then watches the synchronized latch
// output and reports either done or err.
module sr_latch_driver #(
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CMAX = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

  state_t          state, state_n;
  logic            sync1, q_sync;
  logic            lvl, lvl_n;
  logic [CW-1:0]   pcnt, pcnt_n;
  logic [CW-1:0]   tcnt, tcnt_n;
  logic            s_n, r_n, done_n, err_n;
  logic            accept;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // Two-flop synchronizer for the asynchronous latch output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      q_sync <= 1'b0;
    end else begin
      sync1  <= q_fb;
      q_sync <= sync1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lvl   <= 1'b0;
      pcnt  <= '0;
      tcnt  <= '0;
      s     <= 1'b0;
      r     <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      lvl   <= lvl_n;
      pcnt  <= pcnt_n;
      tcnt  <= tcnt_n;
      s     <= s_n;
      r     <= r_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // Next-state and next-output logic. s/r are computed for the following
  // cycle, so they are asserted only while the registered state is PULSE.
  always_comb begin
    state_n = state;
    lvl_n   = lvl;
    pcnt_n  = pcnt;
    tcnt_n  = tcnt;
    s_n     = 1'b0;
    r_n     = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          lvl_n = req_level;
          if (q_sync == req_level) begin
            state_n = WAIT;
            tcnt_n  = '0;
          end else begin
            state_n = PULSE;
            s_n     = req_level;
            r_n     = !req_level;
            pcnt_n  = CW'(PULSE_W - 1);
          end
        end
      end
      PULSE: begin
        if (pcnt == '0) begin
          state_n = WAIT;
          tcnt_n  = '0;
        end else begin
          s_n    = lvl;
          r_n    = !lvl;
          pcnt_n = pcnt - CW'(1);
        end
      end
      WAIT: begin
        if (q_sync == lvl) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (tcnt == CW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          tcnt_n = tcnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver. A behavioural SR latch closes the
// feedback loop. Outputs are sampled on the falling edge of the clock.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst, req_valid, req_level, req_ready;
  logic s, r, q_fb, busy, done, err;
  logic latch_q = 1'b0;
  logic tie0 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Latch model: s sets, r resets, otherwise holds.
  always @(s or r) begin
    if (s) latch_q = 1'b1;
    else if (r) latch_q = 1'b0;
  end
  assign q_fb = tie0 ? 1'b0 : latch_q;

  sr_latch_driver #(.PULSE_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_level(req_level),
    .req_ready(req_ready), .s(s), .r(r), .q_fb(q_fb),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // s and r must never be high together.
  always @(negedge clk) begin
    checks++;
    assert ((s && r) === 1'b0) else begin
      errors++;
      $error("FAIL s_r_exclusive observed=%b expected=0", s && r);
    end
    checks++;
    assert ((done && err) === 1'b0) else begin
      errors++;
      $error("FAIL done_err_exclusive observed=%b expected=0", done && err);
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_level = 1'b0;
    @(negedge clk);
    chk("ready_in_rst", req_ready, 1'b0);
    tick();
    chk("ready_in_rst2", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_s", s, 1'b0);
    chk("rst_r", r, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", req_ready, 1'b1);

    // Test 1: normal set with a fast latch.
    req_valid = 1'b1; req_level = 1'b1;
    tick(); req_valid = 1'b0;                     // cycle 1
    chk("t1_c1_s", s, 1'b1); chk("t1_c1_r", r, 1'b0); chk("t1_c1_busy", busy, 1'b1);
    tick();                                       // cycle 2
    chk("t1_c2_s", s, 1'b1); chk("t1_c2_busy", busy, 1'b1); chk("t1_c2_done", done, 1'b0);
    tick();                                       // cycle 3 (WAIT)
    chk("t1_c3_s", s, 1'b0); chk("t1_c3_busy", busy, 1'b1); chk("t1_c3_done", done, 1'b0);
    tick();                                       // cycle 4
    chk("t1_c4_done", done, 1'b1); chk("t1_c4_busy", busy, 1'b0); chk("t1_c4_ready", req_ready, 1'b1);
    tick();
    chk("t1_c5_done", done, 1'b0);

    // Test 2: latch already at 1, skip path.
    req_valid = 1'b1; req_level = 1'b1;
    tick(); req_valid = 1'b0;                     // cycle 1
    chk("t2_c1_s", s, 1'b0); chk("t2_c1_r", r, 1'b0); chk("t2_c1_busy", busy, 1'b1);
    chk("t2_c1_done", done, 1'b0);
    tick();                                       // cycle 2
    chk("t2_c2_done", done, 1'b1); chk("t2_c2_busy", busy, 1'b0); chk("t2_c2_s", s, 1'b0);
    tick();
    chk("t2_c3_done", done, 1'b0);

    // Test 3: feedback stuck at 0, timeout.
    tie0 = 1'b1;
    tick(); tick(); tick();
    req_valid = 1'b1; req_level = 1'b1;
    tick(); req_valid = 1'b0;                     // cycle 1
    chk("t3_c1_s", s, 1'b1);
    tick();                                       // cycle 2
    chk("t3_c2_s", s, 1'b1);
    for (int c = 3; c <= 10; c++) begin
      tick();
      chk($sformatf("t3_c%0d_s", c), s, 1'b0);
      chk($sformatf("t3_c%0d_busy", c), busy, 1'b1);
      chk($sformatf("t3_c%0d_err", c), err, 1'b0);
      chk($sformatf("t3_c%0d_done", c), done, 1'b0);
    end
    tick();                                       // cycle 11
    chk("t3_c11_err", err, 1'b1); chk("t3_c11_done", done, 1'b0); chk("t3_c11_busy", busy, 1'b0);
    tick();
    chk("t3_c12_err", err, 1'b0);

    // Test 4: back-to-back set (skip) then held reset request.
    tie0 = 1'b0;
    tick(); tick(); tick();
    req_valid = 1'b1; req_level = 1'b1;
    tick(); req_level = 1'b0;                     // cycle 1, valid held
    chk("t4_c1_busy", busy, 1'b1); chk("t4_c1_r", r, 1'b0);
    tick();                                       // cycle 2: done, accepts reset
    chk("t4_c2_done", done, 1'b1); chk("t4_c2_ready", req_ready, 1'b1);
    tick(); req_valid = 1'b0;                     // cycle 3
    chk("t4_c3_r", r, 1'b1); chk("t4_c3_s", s, 1'b0); chk("t4_c3_busy", busy, 1'b1);
    tick();                                       // cycle 4
    chk("t4_c4_r", r, 1'b1);
    tick();                                       // cycle 5
    chk("t4_c5_r", r, 1'b0); chk("t4_c5_done", done, 1'b0);
    tick();                                       // cycle 6
    chk("t4_c6_done", done, 1'b1); chk("t4_c6_busy", busy, 1'b0);

    // Test 5: reset during PULSE.
    tick();
    req_valid = 1'b1; req_level = 1'b1;
    tick(); req_valid = 1'b0;                     // cycle 1
    chk("t5_c1_s", s, 1'b1);
    rst = 1'b1;
    tick();                                       // cycle 2
    chk("t5_c2_s", s, 1'b0); chk("t5_c2_busy", busy, 1'b0); chk("t5_c2_ready", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("t5_ready_after", req_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t5_post%0d_done", c), done, 1'b0);
      chk($sformatf("t5_post%0d_err", c), err, 1'b0);
      chk($sformatf("t5_post%0d_busy", c), busy, 1'b0);
    end

    // Test 6: conflicting request while busy is ignored.
    req_valid = 1'b1; req_level = 1'b0;
    tick(); req_level = 1'b1;                     // cycle 1
    chk("t6_c1_r", r, 1'b1); chk("t6_c1_s", s, 1'b0);
    tick();                                       // cycle 2
    chk("t6_c2_r", r, 1'b1); chk("t6_c2_s", s, 1'b0);
    tick(); req_valid = 1'b0;                     // cycle 3
    chk("t6_c3_r", r, 1'b0); chk("t6_c3_s", s, 1'b0); chk("t6_c3_busy", busy, 1'b1);
    tick();                                       // cycle 4
    chk("t6_c4_done", done, 1'b1); chk("t6_c4_err", err, 1'b0);
    tick();
    chk("t6_c5_busy", busy, 1'b0); chk("t6_c5_s", s, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous command-side driver for the team's cross-coupled SR latch cell.
- Accepts a target-level request over a valid/ready handshake and generates a mutually exclusive, fixed-width set or reset pulse.
- Watches the latch's q output through a 2-flop synchronizer, then reports completion or timeout.
- Sits between clocked control logic and the asynchronous latch.

Parameters:
- PULSE_W, 2: cycles s or r is held high per command (must be >= 1).
- TIMEOUT, 8: WAIT-state cycles allowed for q feedback to match before err (must be >= 1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_level  input  1  target latch level (1 = set, 0 = reset)
- req_ready  output  1  block can accept; equals (state==IDLE) && !rst
- s  output  1  registered set drive to latch
- r  output  1  registered reset drive to latch
- q_fb  input  1  latch q, asynchronous to clk
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse: latch confirmed at requested level
- err  output  1  one-cycle pulse: confirmation timed out

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - Reset values: state=IDLE, s=0, r=0, done=0, err=0, busy=0, both synchronizer flops=0, counters=0, captured level=0.
  - req_ready=0 while rst is high.
- Synchronizer: q_fb -> sync1 -> q_sync, 2 flops; q_sync is the only feedback use.
- Acceptance: a request is accepted on an edge where req_valid && req_ready. req_level is captured into lvl at that edge.
- FSM states: IDLE, PULSE, WAIT.
- IDLE:
  - On accept with q_sync==req_level, go to WAIT; no pulse is issued.
  - On accept otherwise, go to PULSE and load the pulse counter.
- PULSE:
  - s=lvl and r=!lvl for exactly PULSE_W cycles.
  - Then go to WAIT with the timeout counter cleared.
  - q_sync is ignored during PULSE.
- WAIT:
  - s=r=0.
  - Each cycle compare q_sync to lvl.
  - On match: the next cycle has done=1 and state=IDLE.
  - If TIMEOUT WAIT cycles elapse with no match: the next cycle has err=1 and state=IDLE.
  - done and err are never high together.
- Invariant: s and r are never both 1 in any cycle, including around reset.
- Both s and r are 0 whenever the state is not PULSE.
- Latency, normal path with a fast latch: accept at edge E0; s/r high in cycles 1..PULSE_W; WAIT from cycle PULSE_W+1; done at the earliest in cycle PULSE_W+2.
- Latency, skip path: WAIT in cycle 1, done in cycle 2.
- Back-to-back requests:
  - req_ready is high in the same cycle done or err is high, so a new request is accepted on that cycle's edge.
  - req_valid while busy is ignored and not queued; the requester holds it.
- Reset mid-operation: s/r drop to 0 at that edge, the pending command is discarded, and neither done nor err is produced.
- Counters are sized $clog2(max(PULSE_W,TIMEOUT)+1) bits and saturate, never wrapping.
- q_fb glitches during WAIT: the first cycle q_sync==lvl completes the command. No debounce is applied.

Test Plan:
1. Defaults; the bench models the latch combinationally (q follows s/r). Reset, then accept req_level=1 at E0.
   -> s=1 in cycles 1–2, r=0 throughout, WAIT in cycle 3, done=1 only in cycle 4, busy=1 in cycles 1–3.
2. q already 1; request req_level=1.
   -> no s/r pulse, done in cycle 2, busy only in cycle 1.
3. q_fb tied to 0; request req_level=1.
   -> s pulses in cycles 1–2, WAIT in cycles 3–10, err=1 in cycle 11, done never asserted.
4. Back-to-back: set, then a reset request held valid.
   -> second request accepted on the done cycle, r=1 for 2 cycles, and s&&r==0 in every cycle.
5. Assert rst for one cycle in the middle of the PULSE state.
   -> s=0 and busy=0 the following cycle, no done/err, req_ready=1 once rst is low.
6. req_valid toggled while busy with a conflicting level.
   -> ignored: the active command's s/r and result are unchanged.
